// File: rtl/vga_plat_renderer.sv
// VGA timing generator plus multi-band platform renderer, one pixel per clk.
// Latency: all outputs registered one clock after the internal (h,v) counters.
// No backpressure: free-running raster; optional VGA_GRID_EN adds a 32-px debug grid.
module vga_plat_renderer #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SYNC_POL = 0,
  parameter int NUM_PLAT = 2,
  parameter int RGB_W    = 3,
  parameter int CW       = 10
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_PLAT*CW-1:0]    plat_start,
  input  logic [NUM_PLAT*CW-1:0]    plat_end,
  input  logic [NUM_PLAT*RGB_W-1:0] plat_color,
  input  logic [RGB_W-1:0]          bg_color,
  output logic                      hsync,
  output logic                      vsync,
  output logic [RGB_W-1:0]          rgb,
  output logic [CW-1:0]             hcount,
  output logic [CW-1:0]             vcount,
  output logic                      active,
  output logic                      frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST  = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST  = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT_C = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT_C = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_BEG  = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END  = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_BEG  = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END  = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic          SYNC_ON = (SYNC_POL != 0);

  logic [CW-1:0]             h;
  logic [CW-1:0]             v;
  logic                      frame_end;
  logic [NUM_PLAT*CW-1:0]    sh_start;
  logic [NUM_PLAT*CW-1:0]    sh_end;
  logic [NUM_PLAT*RGB_W-1:0] sh_color;
  logic [NUM_PLAT-1:0]       hit;
  logic [RGB_W-1:0]          pix_color;
  logic                      pix_active;
  logic                      in_hs;
  logic                      in_vs;

  assign frame_end  = (h == H_LAST) && (v == V_LAST);
  assign pix_active = (h < H_ACT_C) && (v < V_ACT_C);
  assign in_hs      = (h >= HS_BEG) && (h < HS_END);
  assign in_vs      = (v >= VS_BEG) && (v < VS_END);

  // Raster counters: h every clock, v on h wrap; reset restarts at (0,0).
  always_ff @(posedge clk) begin
    if (reset) begin
      h <= '0;
      v <= '0;
    end else if (h == H_LAST) begin
      h <= '0;
      v <= (v == V_LAST) ? '0 : v + 1'b1;
    end else begin
      h <= h + 1'b1;
    end
  end

  // Geometry shadow: captured only between frames so game logic cannot tear a frame.
  always_ff @(posedge clk) begin
    if (reset || frame_end) begin
      sh_start <= plat_start;
      sh_end   <= plat_end;
      sh_color <= plat_color;
    end
  end

  // Band hit test and priority colour select (lowest index wins, else background).
  always_comb begin
    hit       = '0;
    pix_color = bg_color;
    for (int i = 0; i < NUM_PLAT; i++) begin
      hit[i] = (v >= sh_start[i*CW +: CW]) && (v < sh_end[i*CW +: CW]);
    end
    for (int i = NUM_PLAT - 1; i >= 0; i--) begin
      if (hit[i]) pix_color = sh_color[i*RGB_W +: RGB_W];
    end
`ifdef VGA_GRID_EN
    if ((hit == '0) && ((h[4:0] == 5'd0) || (v[4:0] == 5'd0))) pix_color = ~bg_color;
`else
`endif
  end

  // Output stage: everything registered from the same (h,v) so all outputs stay aligned.
  always_ff @(posedge clk) begin
    if (reset) begin
      hsync       <= ~SYNC_ON;
      vsync       <= ~SYNC_ON;
      rgb         <= '0;
      hcount      <= '0;
      vcount      <= '0;
      active      <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      hsync       <= in_hs ? SYNC_ON : ~SYNC_ON;
      vsync       <= in_vs ? SYNC_ON : ~SYNC_ON;
      rgb         <= pix_active ? pix_color : '0;
      hcount      <= h;
      vcount      <= v;
      active      <= pix_active;
      frame_start <= (h == '0) && (v == '0);
    end
  end

endmodule

// File: tb/tb_vga_plat_renderer.sv
// Directed bench for vga_plat_renderer on a shrunken 80x55 raster (64x48 visible).
// A second instance with SYNC_POL=1 runs in lockstep to check inverted syncs.
// Expected values are hand-computed from the reduced timing constants below.
module tb_vga_plat_renderer;

  localparam int CW = 10;
  localparam int RW = 3;
  localparam int NP = 2;
  // 64+4+8+4 = 80 clocks per line, 48+2+2+3 = 55 lines, 4400 clocks per frame
  localparam int FRAME_CLKS = 4400;

  logic             clk = 1'b0;
  logic             reset;
  logic [NP*CW-1:0] plat_start;
  logic [NP*CW-1:0] plat_end;
  logic [NP*RW-1:0] plat_color;
  logic [RW-1:0]    bg_color;

  logic          hsync, vsync, active, frame_start;
  logic [RW-1:0] rgb;
  logic [CW-1:0] hcount, vcount;

  logic          hsync_p, vsync_p, active_p, frame_start_p;
  logic [RW-1:0] rgb_p;
  logic [CW-1:0] hcount_p, vcount_p;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vga_plat_renderer #(
    .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_ACTIVE(48), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .SYNC_POL(0), .NUM_PLAT(NP), .RGB_W(RW), .CW(CW)
  ) dut (
    .clk(clk), .reset(reset),
    .plat_start(plat_start), .plat_end(plat_end), .plat_color(plat_color),
    .bg_color(bg_color),
    .hsync(hsync), .vsync(vsync), .rgb(rgb),
    .hcount(hcount), .vcount(vcount), .active(active), .frame_start(frame_start)
  );

  vga_plat_renderer #(
    .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_ACTIVE(48), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .SYNC_POL(1), .NUM_PLAT(NP), .RGB_W(RW), .CW(CW)
  ) dut_p (
    .clk(clk), .reset(reset),
    .plat_start(plat_start), .plat_end(plat_end), .plat_color(plat_color),
    .bg_color(bg_color),
    .hsync(hsync_p), .vsync(vsync_p), .rgb(rgb_p),
    .hcount(hcount_p), .vcount(vcount_p), .active(active_p), .frame_start(frame_start_p)
  );

  typedef struct {
    int b0s, b0e, b0c, b1s, b1e, b1c, bg;
    int x, y;
    int rgb, act, hs, vs;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(int b0s, int b0e, int b0c, int b1s, int b1e, int b1c, int bg,
                              int x, int y, int r, int a, int hs, int vs);
    vec_t t;
    t.b0s = b0s; t.b0e = b0e; t.b0c = b0c;
    t.b1s = b1s; t.b1e = b1e; t.b1c = b1c; t.bg = bg;
    t.x = x; t.y = y; t.rgb = r; t.act = a; t.hs = hs; t.vs = vs;
    return t;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic set_cfg(input int b0s, input int b0e, input int b0c,
                         input int b1s, input int b1e, input int b1c, input int bg);
    plat_start = {CW'(b1s), CW'(b0s)};
    plat_end   = {CW'(b1e), CW'(b0e)};
    plat_color = {RW'(b1c), RW'(b0c)};
    bg_color   = RW'(bg);
  endtask

  // Leaves the bench at the negedge where the DUT shows pixel (x,y).
  task automatic wait_pix(input int x, input int y, input string name);
    for (int n = 0; n < FRAME_CLKS + 200; n++) begin
      @(negedge clk);
      if (int'(hcount) == x && int'(vcount) == y) return;
    end
    chk({name, "_timeout"}, 0, 1);
  endtask

  task automatic wait_frame(input string name);
    for (int n = 0; n < FRAME_CLKS + 200; n++) begin
      @(negedge clk);
      if (frame_start) return;
    end
    chk({name, "_timeout"}, 0, 1);
  endtask

  initial begin
    int n_per, lo_cnt, lo_first;
    bit first_grp;
    vec_t t, prev;

    // Table: bg=3'b011 (3), band colours 3'b100 (4) and 3'b010 (2). Entries in raster order per config.
    // Band0 10..20 plus sync/blank probes
    tbl.push_back(mk(10,20,4, 0,0,2, 3,   0, 9, 3,1,1,1));
    tbl.push_back(mk(10,20,4, 0,0,2, 3,   0,10, 4,1,1,1));
    tbl.push_back(mk(10,20,4, 0,0,2, 3,  63,10, 4,1,1,1));
    tbl.push_back(mk(10,20,4, 0,0,2, 3,  64,10, 0,0,1,1));
    tbl.push_back(mk(10,20,4, 0,0,2, 3,  67,10, 0,0,1,1));
    tbl.push_back(mk(10,20,4, 0,0,2, 3,  68,10, 0,0,0,1));
    tbl.push_back(mk(10,20,4, 0,0,2, 3,  75,10, 0,0,0,1));
    tbl.push_back(mk(10,20,4, 0,0,2, 3,  76,10, 0,0,1,1));
    tbl.push_back(mk(10,20,4, 0,0,2, 3,  63,19, 4,1,1,1));
    tbl.push_back(mk(10,20,4, 0,0,2, 3,   0,20, 3,1,1,1));
    tbl.push_back(mk(10,20,4, 0,0,2, 3,   0,47, 3,1,1,1));
    tbl.push_back(mk(10,20,4, 0,0,2, 3,   0,48, 0,0,1,1));
    tbl.push_back(mk(10,20,4, 0,0,2, 3,   0,49, 0,0,1,1));
    tbl.push_back(mk(10,20,4, 0,0,2, 3,   0,50, 0,0,1,0));
    tbl.push_back(mk(10,20,4, 0,0,2, 3,   0,51, 0,0,1,0));
    tbl.push_back(mk(10,20,4, 0,0,2, 3,   0,52, 0,0,1,1));
    // Overlapping bands: band0 5..25 wins over band1 15..35
    tbl.push_back(mk(5,25,4, 15,35,2, 3,  0, 4, 3,1,1,1));
    tbl.push_back(mk(5,25,4, 15,35,2, 3,  0,15, 4,1,1,1));
    tbl.push_back(mk(5,25,4, 15,35,2, 3,  0,24, 4,1,1,1));
    tbl.push_back(mk(5,25,4, 15,35,2, 3,  0,25, 2,1,1,1));
    tbl.push_back(mk(5,25,4, 15,35,2, 3,  0,34, 2,1,1,1));
    tbl.push_back(mk(5,25,4, 15,35,2, 3,  0,35, 3,1,1,1));
    // Empty bands (start==end) draw nothing
    tbl.push_back(mk(30,30,4, 0,0,2, 5,   0, 0, 5,1,1,1));
    tbl.push_back(mk(30,30,4, 0,0,2, 5,   0,30, 5,1,1,1));
    // Empty band0 lets band1 show
    tbl.push_back(mk(30,30,4, 20,40,6, 1, 0,30, 6,1,1,1));
    tbl.push_back(mk(30,30,4, 20,40,6, 1, 0,40, 1,1,1,1));

    // Reset state
    set_cfg(10,20,4, 0,0,2, 3);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_rgb", int'(rgb), 0);
    chk("reset_hsync", int'(hsync), 1);
    chk("reset_vsync", int'(vsync), 1);
    chk("reset_hsync_pol1", int'(hsync_p), 0);
    chk("reset_active", int'(active), 0);
    chk("reset_frame_start", int'(frame_start), 0);
    chk("reset_hcount", int'(hcount), 0);
    reset = 1'b0;
    @(negedge clk);
    chk("first_fs", int'(frame_start), 1);
    chk("first_h", int'(hcount), 0);
    chk("first_v", int'(vcount), 0);
    chk("first_active", int'(active), 1);

    // Frame period
    n_per = -1;
    for (int n = 1; n <= FRAME_CLKS + 200; n++) begin
      @(negedge clk);
      if (frame_start) begin n_per = n; break; end
    end
    chk("frame_period", n_per, FRAME_CLKS);

    // hsync low width and position over one line
    lo_cnt = 0; lo_first = -1;
    for (int k = 0; k < 80; k++) begin
      if (!hsync) begin
        lo_cnt++;
        if (lo_first < 0) lo_first = int'(hcount);
      end
      @(negedge clk);
    end
    chk("hsync_low_clocks", lo_cnt, 8);
    chk("hsync_low_first_h", lo_first, 68);

    // Table-driven vectors; resync to a fresh frame whenever the geometry changes
    first_grp = 1'b1;
    prev = tbl[0];
    foreach (tbl[i]) begin
      t = tbl[i];
      if (first_grp || t.b0s != prev.b0s || t.b0e != prev.b0e || t.b0c != prev.b0c ||
          t.b1s != prev.b1s || t.b1e != prev.b1e || t.b1c != prev.b1c || t.bg != prev.bg) begin
        set_cfg(t.b0s, t.b0e, t.b0c, t.b1s, t.b1e, t.b1c, t.bg);
        repeat (2) @(negedge clk);
        wait_frame($sformatf("vec%0d_frame", i));
        first_grp = 1'b0;
      end
      prev = t;
      wait_pix(t.x, t.y, $sformatf("vec%0d_pix", i));
      chk($sformatf("vec%0d_rgb(%0d,%0d)", i, t.x, t.y), int'(rgb), t.rgb);
      chk($sformatf("vec%0d_active", i), int'(active), t.act);
      chk($sformatf("vec%0d_hsync", i), int'(hsync), t.hs);
      chk($sformatf("vec%0d_vsync", i), int'(vsync), t.vs);
      chk($sformatf("vec%0d_hsync_pol1", i), int'(hsync_p), 1 - t.hs);
      chk($sformatf("vec%0d_vsync_pol1", i), int'(vsync_p), 1 - t.vs);
    end

    // Mid-frame geometry change must wait for the next frame
    set_cfg(10,20,4, 0,0,2, 3);
    repeat (2) @(negedge clk);
    wait_frame("mid_frame0");
    wait_pix(0, 24, "mid_pix24");
    set_cfg(30,40,4, 0,0,2, 3);
    wait_pix(0, 30, "mid_pix30a");
    chk("mid_same_frame_rgb30", int'(rgb), 3);
    wait_frame("mid_frame1");
    wait_pix(0, 10, "mid_pix10");
    chk("mid_next_frame_rgb10", int'(rgb), 3);
    wait_pix(0, 30, "mid_pix30b");
    chk("mid_next_frame_rgb30", int'(rgb), 4);

    // Reset mid-frame while inside a coloured band
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_rgb", int'(rgb), 0);
    chk("midrst_hsync", int'(hsync), 1);
    chk("midrst_vsync", int'(vsync), 1);
    chk("midrst_active", int'(active), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("postrst_fs", int'(frame_start), 1);
    chk("postrst_h", int'(hcount), 0);
    chk("postrst_v", int'(vcount), 0);
    chk("postrst_rgb", int'(rgb), 3);
    @(negedge clk);
    chk("postrst_fs_pulse", int'(frame_start), 0);
    chk("postrst_h1", int'(hcount), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
